seq_step_scheduler: RTL and testbench

//  Shares one 2-bit sequence counter {A,B} between two requesters.

---
 rtl/seq_step_scheduler.sv | 118 +++++++++++
 tb/tb_seq_step_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_step_scheduler.sv
// Round-robin scheduler sharing one 2-bit {A,B} sequence counter between two job requesters.
// Each granted job advances the sequence once per cycle for its requested step count.
//
// state | meaning
// IDLE  | waiting for req0/req1; arbitration happens here only
// RUN   | one step per cycle until the remaining count runs out
// DONE  | done pulse for the owner; round-robin pointer updated
module seq_step_scheduler #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [CNT_W-1:0] cnt0,
    input  logic             mode0,
    input  logic             req1,
    input  logic [CNT_W-1:0] cnt1,
    input  logic             mode1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             step,
    output logic [1:0]       ab
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             owner;
    logic             mode_q;
    logic             last_sel;

    logic             win;
    logic             win_sel;
    logic [CNT_W-1:0] win_cnt;
    logic             win_mode;
    logic             enter_done;
    logic             done_sel;

    // mode 0 walks 00-01-11-10, mode 1 walks 00-11-01-10
    function automatic logic [1:0] seq_next(input logic [1:0] cur, input logic mode);
        logic [1:0] nxt;
        nxt = 2'b00;
        case (cur)
            2'b00:   nxt = mode ? 2'b11 : 2'b01;
            2'b01:   nxt = mode ? 2'b10 : 2'b11;
            2'b11:   nxt = mode ? 2'b01 : 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        win_sel   = 1'b0;
        win_cnt   = cnt0;
        win_mode  = mode0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win       = 1'b1;
                    win_sel   = (req0 && req1) ? ~last_sel : req1;
                    win_cnt   = win_sel ? cnt1 : cnt0;
                    win_mode  = win_sel ? mode1 : mode0;
                    state_nxt = (win_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_done = (state_nxt == DONE) && (state != DONE);
    assign done_sel   = win ? win_sel : owner;
    assign busy       = (state != IDLE);
    assign step       = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ab        <= 2'b00;
            remaining <= '0;
            owner     <= 1'b0;
            mode_q    <= 1'b0;
            last_sel  <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt0  <= win && !win_sel;
            gnt1  <= win && win_sel;
            done0 <= enter_done && !done_sel;
            done1 <= enter_done && done_sel;
            if (win) begin
                owner     <= win_sel;
                mode_q    <= win_mode;
                remaining <= win_cnt;
            end
            if (state == RUN) begin
                ab        <= seq_next(ab, mode_q);
                remaining <= remaining - CNT_W'(1);
            end
            if (state == DONE)
                last_sel <= owner;
        end
    end

endmodule

// File: tb/tb_seq_step_scheduler.sv
// Directed and randomized bench for seq_step_scheduler against a job-timeline reference model.
module tb_seq_step_scheduler;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
    logic [CNT_W-1:0] cnt0 = '0, cnt1 = '0;
    logic             gnt0, gnt1, done0, done1, busy, step;
    logic [1:0]       ab;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_step_scheduler #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .cnt0(cnt0), .mode0(mode0),
        .req1(req1), .cnt1(cnt1), .mode1(mode1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .busy(busy), .step(step), .ab(ab)
    );

    // Reference: a job is a timeline k=1..N+1 after its grant edge; ab is a position along a ring.
    logic [1:0] seq_a [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] seq_b [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    bit         m_idle = 1'b1, m_owner = 1'b0, m_mode = 1'b0, m_last = 1'b1;
    int         m_k = 0, m_n = 0, m_pos0 = 0;
    logic [1:0] m_ab = 2'b00;
    bit         hold0 = 1'b0, hold1 = 1'b0;
    int         grants[$];

    function automatic logic [1:0] seq_at(input bit mode, input int idx);
        return mode ? seq_b[idx % 4] : seq_a[idx % 4];
    endfunction

    function automatic int seq_pos(input bit mode, input logic [1:0] v);
        for (int i = 0; i < 4; i++)
            if (seq_at(mode, i) == v) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_idle = 1'b1; m_ab = 2'b00; m_last = 1'b1;
        end else if (m_idle) begin
            if (req0 || req1) begin
                m_owner = (req0 && req1) ? !m_last : req1;
                m_n     = m_owner ? int'(cnt1) : int'(cnt0);
                m_mode  = m_owner ? mode1 : mode0;
                m_pos0  = seq_pos(m_mode, m_ab);
                m_k     = 1;
                m_idle  = 1'b0;
            end
        end else begin
            m_k++;
            if (m_k == m_n + 2) begin
                m_ab   = seq_at(m_mode, m_pos0 + m_n);
                m_last = m_owner;
                m_idle = 1'b1;
            end
        end
    endtask

    task automatic tick();
        bit e_gnt, e_done, e_step, e_busy;
        logic [1:0] e_ab;
        @(posedge clk);
        model_edge();
        #1;
        e_gnt = 0; e_done = 0; e_step = 0; e_busy = 0; e_ab = m_ab;
        if (!m_idle) begin
            e_busy = 1;
            e_gnt  = (m_k == 1);
            e_step = (m_k <= m_n);
            e_done = (m_k == m_n + 1);
            e_ab   = seq_at(m_mode, m_pos0 + m_k - 1);
        end
        chk("gnt0",  8'(gnt0),  8'(e_gnt && !m_owner));
        chk("gnt1",  8'(gnt1),  8'(e_gnt && m_owner));
        chk("done0", 8'(done0), 8'(e_done && !m_owner));
        chk("done1", 8'(done1), 8'(e_done && m_owner));
        chk("busy",  8'(busy),  8'(e_busy));
        chk("step",  8'(step),  8'(e_step));
        chk("ab",    8'(ab),    8'(e_ab));
        if (gnt0) grants.push_back(0);
        if (gnt1) grants.push_back(1);
        if (gnt0 && !hold0) req0 = 1'b0;
        if (gnt1 && !hold1) req1 = 1'b0;
    endtask

    initial begin
        logic [1:0] ab_before;
        int         cyc;

        // Reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t1_ab", 8'(ab), 8'h00);

        // Single SEQ_A job, 4 steps
        req0 = 1'b1; cnt0 = 4'd4; mode0 = 1'b0;
        repeat (6) tick();
        chk("t2_ab_final", 8'(ab), 8'h00);
        chk("t2_busy_low", 8'(busy), 8'h00);

        // Single SEQ_B job, 3 steps
        req1 = 1'b1; cnt1 = 4'd3; mode1 = 1'b1;
        repeat (6) tick();
        chk("t3_ab_final", 8'(ab), 8'h02);
        repeat (3) tick();
        chk("t3_ab_hold", 8'(ab), 8'h02);

        // Contention with both requests held
        grants.delete();
        hold0 = 1'b1; hold1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1; cnt0 = 4'd2; cnt1 = 4'd2; mode0 = 1'b0; mode1 = 1'b0;
        cyc = 0;
        while (grants.size() < 4 && cyc < 40) begin
            tick();
            cyc++;
        end
        req0 = 1'b0; req1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        chk("t4_grant_count", 8'(grants.size()), 8'd4);
        if (grants.size() >= 4) begin
            chk("t4_order0", 8'(grants[0]), 8'd0);
            chk("t4_order1", 8'(grants[1]), 8'd1);
            chk("t4_order2", 8'(grants[2]), 8'd0);
            chk("t4_order3", 8'(grants[3]), 8'd1);
        end
        repeat (6) tick();

        // Zero-count job
        ab_before = ab;
        req0 = 1'b1; cnt0 = 4'd0; mode0 = 1'b1;
        tick();
        chk("t5_gnt0", 8'(gnt0), 8'h01);
        chk("t5_done0", 8'(done0), 8'h01);
        chk("t5_ab", 8'(ab), 8'(ab_before));
        repeat (3) tick();

        // Reset during the third step cycle of a long job
        req0 = 1'b1; cnt0 = 4'd15; mode0 = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ab", 8'(ab), 8'h00);
        chk("t6_busy", 8'(busy), 8'h00);
        repeat (3) tick();
        req1 = 1'b1; cnt1 = 4'd2; mode1 = 1'b0;
        tick();
        chk("t6_gnt1_first", 8'(gnt1), 8'h01);
        repeat (4) tick();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (!req0) begin
                cnt0 = CNT_W'($urandom_range(0, 15)); mode0 = $urandom_range(0, 1);
                req0 = ($urandom_range(0, 3) == 0);
            end
            if (!req1) begin
                cnt1 = CNT_W'($urandom_range(0, 15)); mode1 = $urandom_range(0, 1);
                req1 = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
